// File: rtl/regfile_2r1w_if.sv
// rtl/regfile_2r1w_if.sv - write/read/clear bus bundle for regfile_2r1w
interface regfile_2r1w_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  d_in;
  logic [ADDR_W-1:0] ra0;
  logic [ADDR_W-1:0] ra1;
  logic              clr;
  logic [WIDTH-1:0]  d_out0;
  logic [WIDTH-1:0]  d_out1;
  logic              busy;

  modport master (
    output we, wa, d_in, ra0, ra1, clr,
    input  d_out0, d_out1, busy
  );

  modport slave (
    input  we, wa, d_in, ra0, ra1, clr,
    output d_out0, d_out1, busy
  );
endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with sequenced bulk clear; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_2r1w #(
  parameter int               WIDTH     = 4,
  parameter int               ADDR_W    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic          clk,
  input logic          reset,
  regfile_2r1w_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  d_out0_q;
  logic [WIDTH-1:0]  d_out1_q;
  logic              wr_acc;
  logic              clr_wr;
  logic              fwd0;
  logic              fwd1;

  // User writes are only taken while no clear sweep is running.
  assign wr_acc = bus.we && (state == IDLE);
  assign clr_wr = (state == CLEAR);

`ifdef REGFILE_BYPASS_EN
  // Forward only user writes; clear-sweep writes are never visible early.
  assign fwd0 = wr_acc && (bus.ra0 == bus.wa);
  assign fwd1 = wr_acc && (bus.ra1 == bus.wa);
`else
  assign fwd0 = 1'b0;
  assign fwd1 = 1'b0;
`endif

  // Clear FSM next-state: one entry per cycle, leave after the last address.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == {ADDR_W{1'b1}}) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM state register; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Storage and registered read ports; reads see pre-write contents unless forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
      d_out0_q <= '0;
      d_out1_q <= '0;
    end else begin
      if (wr_acc) begin
        mem[bus.wa] <= bus.d_in;
      end
      if (clr_wr) begin
        mem[ptr] <= RESET_VAL;
      end
      d_out0_q <= fwd0 ? bus.d_in : mem[bus.ra0];
      d_out1_q <= fwd1 ? bus.d_in : mem[bus.ra1];
    end
  end

  assign bus.d_out0 = d_out0_q;
  assign bus.d_out1 = d_out1_q;
  assign bus.busy   = (state == CLEAR);
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed vector bench for regfile_2r1w
module tb_regfile_2r1w;
  logic clk;
  logic reset;

  regfile_2r1w_if #(.WIDTH(4), .ADDR_W(3)) bus ();

  regfile_2r1w #(.WIDTH(4), .ADDR_W(3), .RESET_VAL(4'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [3:0] d_in;
    logic [2:0] ra0;
    logic [2:0] ra1;
    logic [3:0] e0;
    logic [3:0] e1;
  } vec_t;

  localparam int NV = 15;
`ifdef REGFILE_BYPASS_EN
  localparam logic [3:0] SAME_EDGE_5 = 4'h7;
  localparam logic [3:0] SAME_EDGE_7 = 4'hC;
`else
  localparam logic [3:0] SAME_EDGE_5 = 4'h2;
  localparam logic [3:0] SAME_EDGE_7 = 4'h0;
`endif

  vec_t vecs [NV];
  int   nvec;
  int   nbad;
  int   n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic count_busy(inout int cnt);
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus.busy) cnt++;
      else return;
    end
    chk("busy_timeout", 1, 0);
  endtask

  initial begin
    nvec = 0;
    nbad = 0;

    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b0, 3'd0, 4'h0, 3'(i), 3'(7 - i), 4'h0, 4'h0};
    end
    vecs[8]  = '{1'b1, 3'd3, 4'hA, 3'd0, 3'd0, 4'h0, 4'h0};
    vecs[9]  = '{1'b0, 3'd0, 4'h0, 3'd3, 3'd3, 4'hA, 4'hA};
    vecs[10] = '{1'b1, 3'd5, 4'h2, 3'd3, 3'd4, 4'hA, 4'h0};
    vecs[11] = '{1'b1, 3'd5, 4'h7, 3'd5, 3'd5, SAME_EDGE_5, SAME_EDGE_5};
    vecs[12] = '{1'b0, 3'd0, 4'h0, 3'd5, 3'd3, 4'h7, 4'hA};
    vecs[13] = '{1'b1, 3'd7, 4'hC, 3'd7, 3'd3, SAME_EDGE_7, 4'hA};
    vecs[14] = '{1'b0, 3'd0, 4'h0, 3'd7, 3'd0, 4'hC, 4'h0};

    reset    = 1'b1;
    bus.we   = 1'b0;
    bus.wa   = '0;
    bus.d_in = '0;
    bus.ra0  = '0;
    bus.ra1  = '0;
    bus.clr  = 1'b0;
    tick();
    tick();
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_d_out0", 32'(bus.d_out0), 0);
    chk("reset_d_out1", 32'(bus.d_out1), 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.we   = vecs[i].we;
      bus.wa   = vecs[i].wa;
      bus.d_in = vecs[i].d_in;
      bus.ra0  = vecs[i].ra0;
      bus.ra1  = vecs[i].ra1;
      tick();
      chk($sformatf("vec%0d_d_out0", i), 32'(bus.d_out0), 32'(vecs[i].e0));
      chk($sformatf("vec%0d_d_out1", i), 32'(bus.d_out1), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 0);
    end
    bus.we = 1'b0;

    // Fill with 0xF, bulk clear, writes of 0x5 during the sweep must vanish.
    for (int i = 0; i < 8; i++) begin
      bus.we = 1'b1; bus.wa = 3'(i); bus.d_in = 4'hF;
      tick();
    end
    bus.we  = 1'b0;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_busy_start", 32'(bus.busy), 1);
    n = 1;
    bus.we = 1'b1; bus.wa = 3'd0; bus.d_in = 4'h5;
    count_busy(n);
    bus.we = 1'b0;
    chk("clr_busy_len", n, 8);
    for (int i = 0; i < 8; i++) begin
      bus.ra0 = 3'(i); bus.ra1 = 3'(7 - i);
      tick();
      chk($sformatf("cleared_d_out0_%0d", i), 32'(bus.d_out0), 0);
      chk($sformatf("cleared_d_out1_%0d", i), 32'(bus.d_out1), 0);
    end

    // Reset three cycles into a sweep aborts it and clears everything.
    bus.we = 1'b1; bus.wa = 3'd6; bus.d_in = 4'h3;
    tick();
    bus.we  = 1'b0;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    tick(); tick(); tick();
    chk("midclr_busy", 32'(bus.busy), 1);
    reset = 1'b1; bus.we = 1'b1; bus.wa = 3'd6; bus.d_in = 4'h1; bus.clr = 1'b1;
    tick();
    chk("midclr_reset_busy", 32'(bus.busy), 0);
    chk("midclr_reset_d_out0", 32'(bus.d_out0), 0);
    reset = 1'b0; bus.clr = 1'b0;
    bus.we = 1'b1; bus.wa = 3'd4; bus.d_in = 4'h6;
    tick();
    chk("post_reset_idle", 32'(bus.busy), 0);
    bus.we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.ra0 = 3'(i); bus.ra1 = 3'(i);
      tick();
      chk($sformatf("post_reset_d_out0_%0d", i), 32'(bus.d_out0), (i == 4) ? 32'h6 : 32'h0);
      chk($sformatf("post_reset_d_out1_%0d", i), 32'(bus.d_out1), (i == 4) ? 32'h6 : 32'h0);
    end

    // Write and clr on the same idle edge; clr held high during the sweep is ignored.
    bus.we = 1'b1; bus.wa = 3'd6; bus.d_in = 4'h9; bus.clr = 1'b1;
    tick();
    chk("wclr_busy", 32'(bus.busy), 1);
    bus.we = 1'b0; bus.ra0 = 3'd6; bus.ra1 = 3'd6;
    tick();
    chk("wclr_first_read", 32'(bus.d_out0), 32'h9);
    chk("wclr_busy2", 32'(bus.busy), 1);
    n = 2;
    count_busy(n);
    bus.clr = 1'b0;
    chk("wclr_busy_len", n, 8);
    tick();
    chk("wclr_after_d_out0", 32'(bus.d_out0), 0);
    chk("wclr_after_d_out1", 32'(bus.d_out1), 0);
    chk("wclr_after_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
